// File: rtl/ctrl_pipe_stage.sv
// Multi-stage pipeline register for the decoded control word: stall, per-stage flush,
// per-stage valid bits, valid-gated field outputs and a saturating bubble counter.
module ctrl_pipe_stage #(
  parameter int CTRL_W   = 10,
  parameter int STAGES   = 2,
  parameter int MEMW_BIT = 3,
  parameter int BR_BIT   = 2,
  parameter logic [CTRL_W-1:0] BUBBLE = '0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic [STAGES-1:0] flush,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              mem_write,
  output logic              branch_cond,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("ctrl_pipe_stage: STAGES must be in 1..4");
    end
  endgenerate

  logic [CTRL_W-1:0] s_q    [STAGES];
  logic [CTRL_W-1:0] s_prev [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_prev;
  logic [CNT_W-1:0]  cnt_q;
  logic              v_last_next;

  // s_prev/v_prev give each stage the word it would load when advancing (stage -1 = input).
  assign s_prev[0] = ctrl_in;
  assign v_prev[0] = valid_in;
  generate
    for (genvar k = 1; k < STAGES; k++) begin : g_prev
      assign s_prev[k] = s_q[k-1];
      assign v_prev[k] = v_q[k-1];
    end
  endgenerate

  always_comb begin
    v_last_next = v_prev[STAGES-1];
    if (flush[STAGES-1]) begin
      v_last_next = 1'b0;
    end else if (stall) begin
      v_last_next = v_q[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= BUBBLE;
      end
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush[k]) begin
          s_q[k] <= BUBBLE;
          v_q[k] <= 1'b0;
        end else if (!stall) begin
          s_q[k] <= s_prev[k];
          v_q[k] <= v_prev[k];
        end
      end
      // Counts every edge that leaves the last stage invalid, including stall-holds.
      if (!v_last_next && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ctrl_out    = s_q[STAGES-1];
  assign valid_out   = v_q[STAGES-1];
  assign mem_write   = s_q[STAGES-1][MEMW_BIT] & v_q[STAGES-1];
  assign branch_cond = s_q[STAGES-1][BR_BIT] & v_q[STAGES-1];
  assign stage_valid = v_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage (STAGES=2, CNT_W=4): directed vectors, expected exiting words
// queued at issue time and checked by a negedge monitor as they reach the last stage.
module tb_ctrl_pipe_stage;
  localparam int CTRL_W = 10;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic [CTRL_W-1:0] ctrl_in;
  logic              valid_in;
  logic              stall;
  logic [STAGES-1:0] flush;
  logic [CTRL_W-1:0] ctrl_out;
  logic              valid_out;
  logic              mem_write;
  logic              branch_cond;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;
  logic [CTRL_W-1:0] exp_q[$];

  ctrl_pipe_stage #(
    .CTRL_W(CTRL_W), .STAGES(STAGES), .MEMW_BIT(3), .BR_BIT(2),
    .BUBBLE('0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .valid_out(valid_out),
    .mem_write(mem_write), .branch_cond(branch_cond),
    .stage_valid(stage_valid), .bubble_cnt(bubble_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one set of inputs across one rising edge, return #1 after it
  task automatic cyc(input logic [CTRL_W-1:0] c, input logic v, input logic st,
                     input logic [STAGES-1:0] fl);
    ctrl_in  = c;
    valid_in = v;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard: *_p hold the inputs that applied at the most recent edge
  logic              rst_p = 1'b1;
  logic              adv_p = 1'b0;
  logic [STAGES-1:0] fl_p  = '0;
  logic [CTRL_W-1:0] last_ctrl = '0;
  logic              last_valid = 1'b0;

  always @(negedge clk) begin
    logic [CTRL_W-1:0] e;
    if (!rst_p) begin
      if (adv_p) begin
        if (valid_out) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {22'd0, ctrl_out}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {22'd0, ctrl_out}, {22'd0, e});
            chk("out_mem_write", {31'd0, mem_write}, {31'd0, e[3]});
            chk("out_branch", {31'd0, branch_cond}, {31'd0, e[2]});
          end
        end else begin
          chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
          chk("idle_branch", {31'd0, branch_cond}, 32'd0);
        end
      end else if (fl_p[STAGES-1]) begin
        chk("flushed_last_valid", {31'd0, valid_out}, 32'd0);
      end else begin
        chk("stall_hold_word", {22'd0, ctrl_out}, {22'd0, last_ctrl});
        chk("stall_hold_valid", {31'd0, valid_out}, {31'd0, last_valid});
      end
    end
    last_ctrl  = ctrl_out;
    last_valid = valid_out;
    rst_p = reset;
    adv_p = !reset && !stall && !flush[STAGES-1];
    fl_p  = flush;
  end

  initial begin
    reset = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall = 1'b0; flush = '0;
    @(posedge clk); #1;
    cyc('0, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    chk("rst_ctrl_out", {22'd0, ctrl_out}, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_stage_valid", {30'd0, stage_valid}, 32'd0);
    chk("rst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);

    // 1: flow, latency of two edges
    cyc('0, 1'b0, 1'b0, 2'b00);
    exp_q.push_back(10'h2AC);
    cyc(10'h2AC, 1'b1, 1'b0, 2'b00);
    chk("flow_stage_valid", {30'd0, stage_valid}, 32'h1);
    chk("flow_not_early", {31'd0, valid_out}, 32'd0);
    cyc('0, 1'b0, 1'b0, 2'b00);
    chk("flow_ctrl_out", {22'd0, ctrl_out}, 32'h2AC);
    chk("flow_mem_write", {31'd0, mem_write}, 32'd1);
    chk("flow_branch", {31'd0, branch_cond}, 32'd1);
    chk("flow_bubble_cnt", {28'd0, bubble_cnt}, 32'd2);

    // 2: stall with B in the last stage
    exp_q.push_back(10'h1A5); exp_q.push_back(10'h0C8); exp_q.push_back(10'h333);
    cyc(10'h1A5, 1'b1, 1'b0, 2'b00);
    cyc(10'h0C8, 1'b1, 1'b0, 2'b00);
    cyc(10'h333, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc(10'h3FF, 1'b1, 1'b1, 2'b00);
      chk("stall_ctrl_out", {22'd0, ctrl_out}, 32'h0C8);
      chk("stall_stage_valid", {30'd0, stage_valid}, 32'h3);
    end
    cyc('0, 1'b0, 1'b0, 2'b00);
    chk("stall_release_c", {22'd0, ctrl_out}, 32'h333);
    cyc('0, 1'b0, 1'b0, 2'b00);

    // 3: flush stage 0 as A enters; W ahead of it exits normally
    exp_q.push_back(10'h208);
    cyc(10'h208, 1'b1, 1'b0, 2'b00);
    cyc(10'h3FF, 1'b1, 1'b0, 2'b01);
    chk("flush_w_out", {22'd0, ctrl_out}, 32'h208);
    chk("flush_stage0_dead", {30'd0, stage_valid}, 32'h2);
    cyc('0, 1'b0, 1'b0, 2'b00);
    chk("flush_slot_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_slot_mem_write", {31'd0, mem_write}, 32'd0);
    chk("flush_slot_bubble", {22'd0, ctrl_out}, 32'd0);

    // 4: flush last stage during stall
    exp_q.push_back(10'h00C); exp_q.push_back(10'h155);
    cyc(10'h00C, 1'b1, 1'b0, 2'b00);
    cyc(10'h155, 1'b1, 1'b0, 2'b00);
    cyc(10'h3F0, 1'b1, 1'b1, 2'b10);
    chk("stflush_stage_valid", {30'd0, stage_valid}, 32'h1);
    chk("stflush_ctrl_out", {22'd0, ctrl_out}, 32'd0);
    cyc('0, 1'b0, 1'b0, 2'b00);
    chk("stflush_release", {22'd0, ctrl_out}, 32'h155);
    chk("stflush_release_v", {31'd0, valid_out}, 32'd1);

    // 5: reset with the pipe full
    exp_q.push_back(10'h2A8);
    cyc(10'h2A8, 1'b1, 1'b0, 2'b00);
    cyc(10'h154, 1'b1, 1'b0, 2'b00);
    chk("full_stage_valid", {30'd0, stage_valid}, 32'h3);
    reset = 1'b1;
    cyc(10'h3FF, 1'b1, 1'b1, 2'b00);
    reset = 1'b0;
    chk("midrst_stage_valid", {30'd0, stage_valid}, 32'd0);
    chk("midrst_ctrl_out", {22'd0, ctrl_out}, 32'd0);
    chk("midrst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);

    // 6: saturation of the 4-bit counter over 20 idle edges
    for (int i = 1; i <= 20; i++) begin
      cyc('0, 1'b0, 1'b0, 2'b00);
      chk("sat_bubble_cnt", {28'd0, bubble_cnt}, (i > 15) ? 32'd15 : 32'(i));
    end

    @(negedge clk);
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
